// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } port_e;

    localparam int unsigned LINE_WORDS  = 16;
    localparam int unsigned TMO_CYC_DEF = 63;

    function automatic port_e other_port(input port_e p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Two-way round-robin winner selection; the port that did not win last time takes a tie.
module dmem_port_arbiter_rr_pick
    import dmem_port_arbiter_pkg::*;
(
    input  logic  req1_i,
    input  logic  req2_i,
    input  port_e rr_last_i,
    output logic  gnt_valid_c_o,
    output port_e gnt_id_c_o
);

    always_comb begin
        gnt_valid_c_o = req1_i | req2_i;
        gnt_id_c_o    = P1;
        if (req1_i && req2_i) begin
            gnt_id_c_o = other_port(rr_last_i);
        end else if (req2_i) begin
            gnt_id_c_o = P2;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Sequences one outstanding word-write or line-read at a time from MEM1/MEM2 onto the
// shared multi-cycle data memory, with round-robin grant and a WAIT-state timeout.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LINE_W  = 512,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic              req2,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd2,
    output logic              done1,
    output logic              done2,
    output logic              err,
    output logic [LINE_W-1:0] rd_line,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    state_e              state_q;
    port_e               gnt_q;
    port_e               rr_last_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic                done1_q;
    logic                done2_q;
    logic                err_q;
    logic                busy_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wd_q;
    logic [LINE_W-1:0]   rd_line_q;

    logic                pick_valid;
    port_e               pick_id;
    logic                cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wd_d;
    logic                tmo_hit_d;

    dmem_port_arbiter_rr_pick u_rr_pick (
        .req1_i        (req1),
        .req2_i        (req2),
        .rr_last_i     (rr_last_q),
        .gnt_valid_c_o (pick_valid),
        .gnt_id_c_o    (pick_id)
    );

    // Command of the port that would win arbitration this cycle.
    always_comb begin
        cmd_we_d   = we1;
        cmd_addr_d = a1;
        cmd_wd_d   = wd1;
        if (pick_id == P2) begin
            cmd_we_d   = we2;
            cmd_addr_d = a2;
            cmd_wd_d   = wd2;
        end
        tmo_hit_d = (tmo_cnt_q == TMO_W'(TMO_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= P1;
            rr_last_q  <= P2;
            tmo_cnt_q  <= '0;
            done1_q    <= 1'b0;
            done2_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            rd_line_q  <= '0;
        end else begin
            mem_req_q <= 1'b0;
            done1_q   <= 1'b0;
            done2_q   <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= pick_id;
                        mem_we_q   <= cmd_we_d;
                        mem_addr_q <= cmd_addr_d;
                        mem_wd_q   <= cmd_wd_d;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // done/err are set on entry to RESP so they are visible during RESP.
                    if (mem_ready) begin
                        if (!mem_we_q) begin
                            rd_line_q <= mem_rdata;
                        end
                        done1_q <= (gnt_q == P1);
                        done2_q <= (gnt_q == P2);
                        state_q <= S_RESP;
                    end else if (tmo_hit_d) begin
                        done1_q <= (gnt_q == P1);
                        done2_q <= (gnt_q == P2);
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                S_RESP: begin
                    rr_last_q <= gnt_q;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done1    = done1_q;
    assign done2    = done2_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign rd_line  = rd_line_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized self-checking bench for dmem_port_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LINE_W  = 512;
    localparam int unsigned TMO_CYC = 63;
    localparam int          MEM_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req1 = 1'b0, req2 = 1'b0, we1 = 1'b0, we2 = 1'b0;
    logic [ADDR_W-1:0] a1 = '0, a2 = '0;
    logic [DATA_W-1:0] wd1 = '0, wd2 = '0;
    logic              done1, done2, err, busy, mem_req, mem_we, mem_ready;
    logic [LINE_W-1:0] rd_line, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;

    logic              model_ready = 1'b0, inj_ready = 1'b0;
    logic [LINE_W-1:0] model_rdata = '0, inj_rdata = '0;
    assign mem_ready = model_ready | inj_ready;
    assign mem_rdata = inj_ready ? inj_rdata : model_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Memory model state and reference model state.
    logic [31:0]       mem_arr [MEM_WORDS];
    logic [31:0]       ref_mem [MEM_WORDS];
    int                lat_cfg = 0;
    bit                pend = 0;
    int                pend_cnt = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    bit                outst = 0;
    int                mreq_cnt = 0;
    int                mreq_viol = 0;
    int                ref_last = 2;
    logic [LINE_W-1:0] ref_rd = '0;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .req2(req2), .we1(we1), .we2(we2),
        .a1(a1), .a2(a2), .wd1(wd1), .wd2(wd2),
        .done1(done1), .done2(done2), .err(err), .rd_line(rd_line), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LINE_W-1:0] mdl_line(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] l;
        int base;
        base = int'(a[11:6]) * int'(LINE_WORDS);
        for (int i = 0; i < int'(LINE_WORDS); i++) l[i*32 +: 32] = mem_arr[base + i];
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] ref_line(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] l;
        int base;
        base = int'(a[11:6]) * int'(LINE_WORDS);
        for (int i = 0; i < int'(LINE_WORDS); i++) l[i*32 +: 32] = ref_mem[base + i];
        return l;
    endfunction

    function automatic int ref_pick(input bit r1, input bit r2);
        if (r1 && r2) return (ref_last == 1) ? 2 : 1;
        return r1 ? 1 : 2;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'(($urandom_range(0, 7) * 64) + ($urandom_range(0, 15) * 4));
    endfunction

    // Memory with programmable READY latency, plus a mem_req protocol monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_ready = 1'b0;
            if (rst) begin
                pend  = 0;
                outst = 0;
            end else begin
                if (done1 || done2) outst = 0;
                if (mem_req) begin
                    if (outst) mreq_viol++;
                    outst = 1;
                    mreq_cnt++;
                    pend = 1;
                    pend_cnt = 0;
                    pend_addr = mem_addr;
                    if (mem_we) mem_arr[mem_addr[11:2]] = mem_wd;
                end else if (pend) begin
                    pend_cnt++;
                    if (lat_cfg > 0 && pend_cnt == lat_cfg) begin
                        model_ready = 1'b1;
                        model_rdata = mdl_line(pend_addr);
                        pend = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req1 = 1'b0; req2 = 1'b0; inj_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        ref_last = 2;
        ref_rd = '0;
    endtask

    // Issues up to two simultaneous requests and checks order, latency, err and rd_line.
    task automatic run_pair(input string nm, input bit r1, input bit r2,
                            input bit w1, input logic [ADDR_W-1:0] ad1, input logic [DATA_W-1:0] d1,
                            input bit w2, input logic [ADDR_W-1:0] ad2, input logic [DATA_W-1:0] d2,
                            input int lat);
        int n_exp, n_got, t0, start, exp_done, p;
        int gp [2];
        int gc [2];
        logic ge [2];
        logic [LINE_W-1:0] gl [2];
        logic [LINE_W-1:0] exp_line;
        bit rem1, rem2, pw;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        lat_cfg = lat;
        req1 = r1; we1 = w1; a1 = ad1; wd1 = d1;
        req2 = r2; we2 = w2; a2 = ad2; wd2 = d2;
        t0 = cyc;
        n_exp = int'(r1) + int'(r2);
        n_got = 0;
        for (int i = 0; i < 400 && n_got < n_exp; i++) begin
            tick();
            if (done1 && n_got < 2) begin
                gp[n_got] = 1; gc[n_got] = cyc; ge[n_got] = err; gl[n_got] = rd_line;
                n_got++; req1 = 1'b0;
            end
            if (done2 && n_got < 2) begin
                gp[n_got] = 2; gc[n_got] = cyc; ge[n_got] = err; gl[n_got] = rd_line;
                n_got++; req2 = 1'b0;
            end
        end
        req1 = 1'b0; req2 = 1'b0;
        checks++;
        if (n_got != n_exp) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", nm, n_got, n_exp);
        end
        rem1 = r1; rem2 = r2; start = t0;
        for (int k = 0; k < n_got && k < n_exp; k++) begin
            p = ref_pick(rem1, rem2);
            if (p == 1) rem1 = 0; else rem2 = 0;
            ref_last = p;
            pw = (p == 1) ? w1 : w2;
            pa = (p == 1) ? ad1 : ad2;
            pd = (p == 1) ? d1 : d2;
            exp_done = start + lat + 2;
            start = exp_done + 1;
            if (pw) ref_mem[pa[11:2]] = pd;
            else    ref_rd = ref_line(pa);
            exp_line = ref_rd;
            checks++;
            if (gp[k] != p) begin
                failures++;
                $display("FAIL %s_port[%0d] got=%0d exp=%0d", nm, k, gp[k], p);
            end
            checks++;
            if (gc[k] != exp_done) begin
                failures++;
                $display("FAIL %s_latency[%0d] got=%0d exp=%0d", nm, k, gc[k] - t0, exp_done - t0);
            end
            checks++;
            if (ge[k] !== 1'b0) begin
                failures++;
                $display("FAIL %s_err[%0d] got=%b exp=0", nm, k, ge[k]);
            end
            checks++;
            if (gl[k] !== exp_line) begin
                failures++;
                $display("FAIL %s_line[%0d] got=%h exp=%h", nm, k, gl[k], exp_line);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done1 !== 1'b0 || done2 !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_after got=%b%b%b exp=000", nm, busy, done1, done2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if ({done1, done2, err} !== 3'b000) begin
            failures++; $display("FAIL reset_done_err got=%b exp=000", {done1, done2, err});
        end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_mem_cmd got=%b%b exp=00", mem_req, mem_we);
        end
        checks++;
        if (mem_addr !== '0 || mem_wd !== '0) begin
            failures++; $display("FAIL reset_mem_regs got=%h/%h exp=0/0", mem_addr, mem_wd);
        end
        checks++;
        if (rd_line !== '0) begin failures++; $display("FAIL reset_rd_line got=%h exp=0", rd_line); end
        rst = 1'b0;
        ref_last = 2;
        ref_rd = '0;
    endtask

    task automatic test_single_read();
        int base_cnt, bad;
        for (int i = 0; i < int'(LINE_WORDS); i++) begin
            mem_arr[16 + i] = 32'(i);
            ref_mem[16 + i] = 32'(i);
        end
        base_cnt = mreq_cnt;
        run_pair("single", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0, 20);
        checks++;
        if (mreq_cnt - base_cnt != 1) begin
            failures++; $display("FAIL single_mem_req_count got=%0d exp=1", mreq_cnt - base_cnt);
        end
        bad = 0;
        for (int i = 0; i < int'(LINE_WORDS); i++) if (rd_line[i*32 +: 32] !== 32'(i)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL single_words got=%0d_bad exp=0_bad", bad); end
    endtask

    task automatic test_fairness();
        int lat, t0, start, exp_done, n, p, base_cnt, base_viol;
        logic [ADDR_W-1:0] ad1, ad2;
        int gp [4];
        int gc [4];
        logic [LINE_W-1:0] gl [4];
        apply_reset();
        lat = int'($urandom_range(1, 6));
        lat_cfg = lat;
        ad1 = rand_addr();
        ad2 = rand_addr();
        base_cnt = mreq_cnt;
        base_viol = mreq_viol;
        req1 = 1'b1; we1 = 1'b0; a1 = ad1; wd1 = $urandom;
        req2 = 1'b1; we2 = 1'b0; a2 = ad2; wd2 = $urandom;
        t0 = cyc;
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            tick();
            if (done1 || done2) begin
                gp[n] = (done1 && done2) ? 3 : (done1 ? 1 : 2);
                gc[n] = cyc;
                gl[n] = rd_line;
                n++;
                if (n == 4) begin req1 = 1'b0; req2 = 1'b0; end
            end
        end
        req1 = 1'b0; req2 = 1'b0;
        checks++;
        if (n != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", n); end
        start = t0;
        for (int k = 0; k < n; k++) begin
            p = ref_pick(1'b1, 1'b1);
            ref_last = p;
            exp_done = start + lat + 2;
            start = exp_done + 1;
            ref_rd = ref_line((p == 1) ? ad1 : ad2);
            checks++;
            if (gp[k] != p) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, gp[k], p); end
            checks++;
            if (gc[k] != exp_done) begin
                failures++; $display("FAIL rr_latency[%0d] got=%0d exp=%0d", k, gc[k] - t0, exp_done - t0);
            end
            checks++;
            if (gl[k] !== ref_rd) begin failures++; $display("FAIL rr_line[%0d] got=%h exp=%h", k, gl[k], ref_rd); end
        end
        tick();
        checks++;
        if (mreq_cnt - base_cnt != 4) begin
            failures++; $display("FAIL rr_mem_req_count got=%0d exp=4", mreq_cnt - base_cnt);
        end
        checks++;
        if (mreq_viol != base_viol) begin
            failures++; $display("FAIL rr_overlap got=%0d exp=0", mreq_viol - base_viol);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        run_pair("conflict", 1'b1, 1'b1, 1'b1, 32'h84, 32'hDEADBEEF, 1'b0, 32'h80, 32'h0,
                 int'($urandom_range(1, 6)));
        checks++;
        if (rd_line[63:32] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL conflict_word1 got=%h exp=deadbeef", rd_line[63:32]);
        end
    endtask

    task automatic test_timeout();
        int t0, got;
        logic ge;
        logic [LINE_W-1:0] gl;
        lat_cfg = 0;
        req2 = 1'b1; we2 = 1'b0; a2 = rand_addr();
        t0 = cyc;
        got = -1;
        ge = 1'b0;
        gl = '0;
        for (int i = 0; i < 200 && got < 0; i++) begin
            tick();
            if (done2) begin got = cyc; ge = err; gl = rd_line; req2 = 1'b0; end
        end
        req2 = 1'b0;
        ref_last = 2;
        checks++;
        if (got != t0 + int'(TMO_CYC) + 3) begin
            failures++; $display("FAIL tmo_latency got=%0d exp=%0d", got - t0, TMO_CYC + 3);
        end
        checks++;
        if (ge !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", ge); end
        checks++;
        if (gl !== ref_rd) begin failures++; $display("FAIL tmo_rd_line got=%h exp=%h", gl, ref_rd); end
        tick();
        checks++;
        if (err !== 1'b0 || done2 !== 1'b0) begin
            failures++; $display("FAIL tmo_pulse_len got=%b%b exp=00", err, done2);
        end
    endtask

    task automatic test_reset_midflight();
        int t0, ndone;
        lat_cfg = 0;
        req1 = 1'b1; we1 = 1'b0; a1 = rand_addr();
        t0 = cyc;
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL rstmid_waiting got=%b%b exp=10", busy, mem_req);
        end
        rst = 1'b1;
        req1 = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || done1 !== 1'b0) begin
            failures++; $display("FAIL rstmid_abort got=%b%b%b exp=000", busy, mem_req, done1);
        end
        rst = 1'b0;
        ref_last = 2;
        ref_rd = '0;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done1 || done2) ndone++;
        end
        checks++;
        if (ndone != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        run_pair("post_rst", 1'b1, 1'b0, 1'b0, rand_addr(), 32'h0, 1'b0, 32'h0, 32'h0,
                 int'($urandom_range(1, 6)));
    endtask

    task automatic test_ready_outside_wait();
        int t0, k, got;
        logic [ADDR_W-1:0] ad;
        logic [LINE_W-1:0] gl;
        lat_cfg = 0;
        ad = rand_addr();
        for (int i = 0; i < LINE_W / 32; i++) inj_rdata[i*32 +: 32] = $urandom;
        inj_ready = 1'b1;
        tick();
        req2 = 1'b1; we2 = 1'b0; a2 = ad;
        t0 = cyc;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL ow_issue got=%b exp=1", mem_req); end
        tick();
        inj_ready = 1'b0;
        k = int'($urandom_range(1, 8));
        repeat (k) tick();
        inj_rdata = mdl_line(ad);
        inj_ready = 1'b1;
        tick();
        inj_ready = 1'b0;
        got = -1;
        gl = '0;
        for (int i = 0; i < 200 && got < 0; i++) begin
            if (done2) begin got = cyc; gl = rd_line; req2 = 1'b0; end
            else tick();
        end
        req2 = 1'b0;
        ref_last = 2;
        ref_rd = ref_line(ad);
        checks++;
        if (got != t0 + 3 + k) begin
            failures++; $display("FAIL ow_latency got=%0d exp=%0d", got - t0, 3 + k);
        end
        checks++;
        if (gl !== ref_rd) begin failures++; $display("FAIL ow_line got=%h exp=%h", gl, ref_rd); end
        tick();
    endtask

    task automatic test_random();
        bit r1, r2;
        for (int it = 0; it < 12; it++) begin
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            if (!r1 && !r2) r1 = 1'b1;
            run_pair($sformatf("rand%0d", it), r1, r2,
                     1'($urandom_range(0, 1)), rand_addr(), $urandom,
                     1'($urandom_range(0, 1)), rand_addr(), $urandom,
                     int'($urandom_range(1, 6)));
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < MEM_WORDS; i++) begin
            v = $urandom;
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_single_read();
        test_fairness();
        test_conflict();
        test_timeout();
        test_reset_midflight();
        test_ready_outside_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
